// File: rtl/heap_arbiter.sv
// ============================================================================
// Module   : heap_arbiter
// Purpose  : Round-robin arbiter that serializes NREQ requesters onto a single
//            heap engine (make_heap / push / pop) and returns one-hot responses.
// Options  : HEAP_ARB_TIMEOUT_EN adds a 12-bit watchdog on the engine wait.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module heap_arbiter #(
  parameter int NREQ     = 4,
  parameter int KEY_W    = 32,
  parameter int CAPACITY = 1023
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [KEY_W*NREQ-1:0] req_key,
  output logic [NREQ-1:0]       resp_valid,
  output logic [KEY_W-1:0]      resp_data,
  output logic                  resp_err,
  output logic                  heap_start,
  output logic [1:0]            heap_instruction,
  output logic [KEY_W-1:0]      heap_key,
  input  logic                  heap_done,
  input  logic [KEY_W-1:0]      heap_arr_out,
  input  logic [9:0]            heap_n,
  output logic                  busy
);

  localparam int                IDX_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDX_W:0]    C_NREQ    = (IDX_W + 1)'(NREQ);
  localparam logic [IDX_W-1:0]  C_LAST    = IDX_W'(NREQ - 1);
  localparam logic [9:0]        C_CAP     = 10'(CAPACITY);
  localparam logic [1:0]        C_OP_PUSH = 2'b01;
  localparam logic [1:0]        C_OP_POP  = 2'b10;
  localparam logic [1:0]        C_OP_RSVD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_grant;
  logic [1:0]         r_op;
  logic [KEY_W-1:0]   r_key;
  logic [KEY_W-1:0]   r_result;
  logic               r_err;

  logic [1:0]         w_op_arr  [NREQ];
  logic [KEY_W-1:0]   w_key_arr [NREQ];
  logic               w_any;
  logic [IDX_W-1:0]   w_sel;
  logic [IDX_W:0]     w_sum;
  logic [1:0]         w_sel_op;
  logic [KEY_W-1:0]   w_sel_key;
  logic               w_reject;
  logic               w_timeout;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_op_arr[g]  = req_op[2*g +: 2];
    assign w_key_arr[g] = req_key[KEY_W*g +: KEY_W];
  end

  // First asserting requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_sum = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = {1'b0, r_rr_ptr} + (IDX_W + 1)'(i);
      if (w_sum >= C_NREQ) begin
        w_sum = w_sum - C_NREQ;
      end
      if (!w_any && req_valid[w_sum[IDX_W-1:0]]) begin
        w_any = 1'b1;
        w_sel = w_sum[IDX_W-1:0];
      end
    end
  end

  assign w_sel_op  = w_op_arr[w_sel];
  assign w_sel_key = w_key_arr[w_sel];

  always_comb begin
    w_reject = 1'b0;
    case (w_sel_op)
      C_OP_PUSH: w_reject = (heap_n >= C_CAP);
      C_OP_POP:  w_reject = (heap_n == 10'd0);
      C_OP_RSVD: w_reject = 1'b1;
      default:   w_reject = 1'b0;
    endcase
  end

`ifdef HEAP_ARB_TIMEOUT_EN
  logic [11:0] r_wdog;

  // Counts completed WAIT cycles; fires on the 4095th without heap_done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wdog <= '0;
    end else if (r_state == S_WAIT) begin
      r_wdog <= r_wdog + 12'd1;
    end else begin
      r_wdog <= '0;
    end
  end

  assign w_timeout = (r_state == S_WAIT) && !heap_done && (r_wdog == 12'd4094);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    busy             = (r_state != S_IDLE);
    heap_start       = 1'b0;
    heap_instruction = '0;
    heap_key         = '0;
    resp_valid       = '0;
    resp_data        = '0;
    resp_err         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req_valid) begin
          w_state_nxt = S_ARB;
        end
      end
      S_ARB: begin
        if (!w_any) begin
          w_state_nxt = S_IDLE;
        end else if (w_reject) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        heap_start       = 1'b1;
        heap_instruction = r_op;
        heap_key         = r_key;
        w_state_nxt      = S_WAIT;
      end
      S_WAIT: begin
        heap_instruction = r_op;
        heap_key         = r_key;
        if (heap_done || w_timeout) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        for (int i = 0; i < NREQ; i++) begin
          resp_valid[i] = (r_grant == IDX_W'(i));
        end
        resp_data   = r_result;
        resp_err    = r_err;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_op     <= '0;
      r_key    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == S_ARB && w_any) begin
        r_grant  <= w_sel;
        r_op     <= w_sel_op;
        r_key    <= w_sel_key;
        r_err    <= w_reject;
        r_result <= (!w_reject && w_sel_op == C_OP_POP) ? heap_arr_out : '0;
      end
      if (w_timeout) begin
        r_err    <= 1'b1;
        r_result <= '0;
      end
      if (r_state == S_RESP) begin
        r_rr_ptr <= (r_grant == C_LAST) ? '0 : r_grant + IDX_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_heap_arbiter.sv
// ============================================================================
// Module   : tb_heap_arbiter
// Purpose  : Scoreboard bench for heap_arbiter with a fixed-latency engine model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_heap_arbiter;
  localparam int NREQ     = 4;
  localparam int KEY_W    = 32;
  localparam int DONE_LAT = 5;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NREQ-1:0]       req_valid;
  logic [2*NREQ-1:0]     req_op;
  logic [KEY_W*NREQ-1:0] req_key;
  logic [NREQ-1:0]       resp_valid;
  logic [KEY_W-1:0]      resp_data;
  logic                  resp_err;
  logic                  heap_start;
  logic [1:0]            heap_instruction;
  logic [KEY_W-1:0]      heap_key;
  logic                  heap_done;
  logic [KEY_W-1:0]      heap_arr_out;
  logic [9:0]            heap_n;
  logic                  busy;

  always #5 clk = ~clk;

  heap_arbiter #(.NREQ(NREQ), .KEY_W(KEY_W), .CAPACITY(1023)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_op           (req_op),
    .req_key          (req_key),
    .resp_valid       (resp_valid),
    .resp_data        (resp_data),
    .resp_err         (resp_err),
    .heap_start       (heap_start),
    .heap_instruction (heap_instruction),
    .heap_key         (heap_key),
    .heap_done        (heap_done),
    .heap_arr_out     (heap_arr_out),
    .heap_n           (heap_n),
    .busy             (busy)
  );

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] key;
  } cmd_t;

  resp_t       resp_q[$];
  cmd_t        cmd_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  int          eng_cnt;
  logic        eng_stall = 1'b0;
  logic        done_inj  = 1'b0;
  resp_t       mon_e;
  cmd_t        mon_c;
  logic        cmd_active = 1'b0;
  logic [1:0]  act_op;
  logic [31:0] act_key;

  always @(posedge clk) cyc <= cyc + 1;

  // Engine answers heap_done exactly DONE_LAT cycles after heap_start.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) eng_cnt <= 0;
    else if (heap_start) eng_cnt <= DONE_LAT;
    else if (eng_cnt != 0) eng_cnt <= eng_cnt - 1;
  end
  assign heap_done = ((eng_cnt == 1) && !eng_stall) || done_inj;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      cmd_active = 1'b0;
    end else begin
      if (cmd_active && !heap_start) begin
        if (resp_valid != '0 || !busy) begin
          cmd_active = 1'b0;
        end else begin
          check("cmd_op_stable", 64'(heap_instruction), 64'(act_op));
          check("cmd_key_stable", 64'(heap_key), 64'(act_key));
        end
      end
      if (heap_start) begin
        if (cmd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_heap_start: actual op=%0d key=%0h required none", heap_instruction, heap_key);
        end else begin
          mon_c = cmd_q.pop_front();
          check("cmd_op", 64'(heap_instruction), 64'(mon_c.op));
          check("cmd_key", 64'(heap_key), 64'(mon_c.key));
        end
        cmd_active = 1'b1;
        act_op     = heap_instruction;
        act_key    = heap_key;
      end
      if (resp_valid != '0) begin
        if (resp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: actual resp_valid=%b required none", resp_valid);
        end else begin
          mon_e = resp_q.pop_front();
          check("resp_valid", 64'(resp_valid), 64'(1) << mon_e.idx);
          check("resp_data", 64'(resp_data), 64'(mon_e.data));
          check("resp_err", 64'(resp_err), 64'(mon_e.err));
          if (mon_e.cyc >= 0) check("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
        end
      end
    end
  end

  task automatic drive(input int idx, input logic [1:0] op, input logic [31:0] key);
    req_op[idx*2 +: 2]      = op;
    req_key[idx*KEY_W +: KEY_W] = key;
    req_valid[idx]          = 1'b1;
  endtask

  task automatic expect_resp(input int idx, input logic [31:0] data, input logic err, input int c);
    resp_t e;
    e.idx = idx; e.data = data; e.err = err; e.cyc = c;
    resp_q.push_back(e);
  endtask

  task automatic expect_cmd(input logic [1:0] op, input logic [31:0] key);
    cmd_t c;
    c.op = op; c.key = key;
    cmd_q.push_back(c);
  endtask

  task automatic wait_resp(input int idx, input int bound);
    int n;
    n = 0;
    @(negedge clk);
    while (!resp_valid[idx] && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!resp_valid[idx]) begin
      errors++;
      $display("FAIL wait_resp%0d: actual no response within %0d cycles, required response", idx, bound);
    end
    req_valid[idx] = 1'b0;
  endtask

  task automatic single(input int idx, input logic [1:0] op, input logic [31:0] key,
                        input logic [31:0] data, input logic err, input int lat, input int bound);
    @(negedge clk);
    drive(idx, op, key);
    expect_resp(idx, data, err, cyc + lat);
    if (!err) expect_cmd(op, key);
    wait_resp(idx, bound);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: actual simulation still running, required finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int t;
    int w;
    reset_n      = 1'b0;
    req_valid    = 4'b1111;
    req_op       = '0;
    req_key      = '0;
    heap_n       = 10'd0;
    heap_arr_out = '0;
    repeat (3) @(negedge clk);
    check("reset_resp", 64'({resp_valid, resp_data, resp_err}), 64'(0));
    check("reset_cmd", 64'({heap_start, heap_instruction, heap_key, busy}), 64'(0));
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;

    // Stray heap_done while idle must be ignored.
    @(negedge clk);
    done_inj = 1'b1;
    repeat (2) @(negedge clk);
    done_inj = 1'b0;
    check("idle_after_stray_done", 64'(busy), 64'(0));

    heap_n = 10'd3;
    single(0, 2'b01, 32'd15, 32'd0, 1'b0, 8, 50);
    heap_n = 10'd10; heap_arr_out = 32'd42;
    single(2, 2'b10, 32'd7, 32'd42, 1'b0, 8, 50);
    heap_n = 10'd0;
    single(1, 2'b10, 32'd0, 32'd0, 1'b1, 2, 50);
    heap_n = 10'd1023;
    single(3, 2'b01, 32'd9, 32'd0, 1'b1, 2, 50);
    heap_n = 10'd5;
    single(0, 2'b11, 32'd5, 32'd0, 1'b1, 2, 50);
    single(1, 2'b00, 32'd21, 32'd0, 1'b0, 8, 50);

    // Requester 1 pulses while the engine is busy and must not be served.
    @(negedge clk);
    drive(2, 2'b01, 32'd99);
    expect_resp(2, 32'd0, 1'b0, cyc + 8);
    expect_cmd(2'b01, 32'd99);
    repeat (4) @(negedge clk);
    drive(1, 2'b01, 32'd55);
    repeat (2) @(negedge clk);
    req_valid[1] = 1'b0;
    wait_resp(2, 50);
    repeat (6) @(negedge clk);
    check("dropped_req_idle", 64'(busy), 64'(0));

    // Reset while waiting on the engine abandons the op.
    @(negedge clk);
    drive(3, 2'b01, 32'd77);
    expect_cmd(2'b01, 32'd77);
    repeat (4) @(negedge clk);
    reset_n   = 1'b0;
    req_valid = '0;
    #1;
    check("wait_reset_resp", 64'({resp_valid, resp_data, resp_err}), 64'(0));
    check("wait_reset_cmd", 64'({heap_start, heap_instruction, heap_key, busy}), 64'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    @(negedge clk);
    drive(1, 2'b01, 32'd11);
    drive(3, 2'b01, 32'd33);
    t = cyc;
    expect_resp(1, 32'd0, 1'b0, t + 8);
    expect_resp(3, 32'd0, 1'b0, t + 17);
    expect_cmd(2'b01, 32'd11);
    expect_cmd(2'b01, 32'd33);
    wait_resp(1, 50);
    wait_resp(3, 50);
    @(negedge clk);

    // All four held high for eight ops.
    @(negedge clk);
    t = cyc;
    for (int i = 0; i < 4; i++) drive(i, 2'b01, 32'(100 + i));
    for (int n = 0; n < 8; n++) begin
      expect_resp(n % 4, 32'd0, 1'b0, t + 8 + 9 * n);
      expect_cmd(2'b01, 32'(100 + n % 4));
    end
    for (int n = 0; n < 8; n++) begin
      w = 0;
      @(negedge clk);
      while (resp_valid == '0 && w < 50) begin
        @(negedge clk);
        w++;
      end
      checks++;
      if (resp_valid == '0) begin
        errors++;
        $display("FAIL fair_wait: actual no response %0d within 50 cycles, required response", n);
      end
    end
    req_valid = '0;
    repeat (2) @(negedge clk);

`ifdef HEAP_ARB_TIMEOUT_EN
    eng_stall = 1'b1;
    single(0, 2'b01, 32'd3, 32'd0, 1'b1, 4098, 4200);
    eng_stall = 1'b0;
`endif

    repeat (5) @(negedge clk);
    check("resp_q_drained", 64'(resp_q.size()), 64'(0));
    check("cmd_q_drained", 64'(cmd_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/heap_arbiter.md
HEAP_ARBITER -- requirements
Module: heap_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter KEY_W, default 32, giving the key/result width.
REQ-003 The block SHALL have parameter CAPACITY, default 1023, giving the maximum heap occupancy (at most 1023, fits a 10-bit count).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req_valid, input, NREQ bits: per-requester request.
REQ-007 The block SHALL have port req_op, input, 2*NREQ bits: per-requester op, 00 make_heap, 01 push, 10 pop, 11 reserved.
REQ-008 The block SHALL have port req_key, input, KEY_W*NREQ bits: per-requester push key.
REQ-009 The block SHALL have port resp_valid, output, NREQ bits: one-hot, one-cycle completion pulse.
REQ-010 The block SHALL have port resp_data, output, KEY_W bits: popped value, valid with resp_valid.
REQ-011 The block SHALL have port resp_err, output, 1 bit: rejected or aborted op, valid with resp_valid.
REQ-012 The block SHALL have ports heap_start (1), heap_instruction (2) and heap_key (KEY_W), outputs: the engine command.
REQ-013 The block SHALL have ports heap_done (1), heap_arr_out (KEY_W, current heap top) and heap_n (10, occupancy), inputs: the engine status.
REQ-014 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, ARB, ISSUE, WAIT and RESP.
REQ-016 In IDLE, if any req_valid is set, the FSM SHALL go to ARB on the next cycle.
REQ-017 ARB SHALL grant using round-robin, searching from index rr_ptr upward with wrap, and SHALL latch the grant index, op and key.
REQ-018 ARB SHALL reject, without engine access, these ops: push when heap_n == CAPACITY; pop when heap_n == 0; op 11. A rejected op SHALL go to RESP with resp_err=1.
REQ-019 In ARB, for an accepted pop, the block SHALL capture heap_arr_out into the result register.
REQ-020 ISSUE SHALL last exactly one cycle, with heap_start=1 and heap_instruction/heap_key driven from latched values, then go to WAIT.
REQ-021 heap_instruction and heap_key SHALL stay stable from ISSUE through WAIT.
REQ-022 heap_start SHALL be 0 outside ISSUE.
REQ-023 WAIT SHALL exit to RESP on the first cycle heap_done=1.
REQ-024 heap_done while not in WAIT SHALL be ignored.
REQ-025 RESP SHALL last one cycle: resp_valid[grant]=1 and resp_data = result register (0 for non-pop ops). rr_ptr SHALL become (grant+1) mod NREQ, and the FSM SHALL go to IDLE.
REQ-026 Minimum latency from req_valid rise (in IDLE) to resp_valid SHALL be 3 cycles plus the engine's done latency; a rejected op SHALL take exactly 2 cycles.
REQ-027 A requester SHALL hold req_valid, op and key stable until its resp_valid. The block SHALL sample them only in ARB.
REQ-028 A requester that drops req_valid before being granted SHALL NOT be served.
REQ-029 Back-to-back: a requester still asserting after its response SHALL wait at least until all other asserting requesters are served once.
REQ-030 With simultaneous requests from all NREQ requesters, each SHALL be served exactly once in round-robin order before any is served twice.

Reset
REQ-031 While reset_n=0, the block SHALL force state=IDLE and rr_ptr=0, and hold all outputs at 0: resp_valid, resp_data, resp_err, heap_start, heap_instruction, heap_key and busy.
REQ-032 Reset assertion mid-operation (ISSUE/WAIT) SHALL abandon the op with no response pulse. After reset release, the first grant SHALL go to the lowest asserting index.

Configuration
REQ-033 With macro HEAP_ARB_TIMEOUT_EN defined, a 12-bit watchdog SHALL count cycles in WAIT. If it reaches 4095 without heap_done, the FSM SHALL go to RESP with resp_err=1 and resp_data=0.
REQ-034 Without HEAP_ARB_TIMEOUT_EN, no watchdog SHALL exist and WAIT SHALL be unbounded.

Verification
REQ-035 Single push: req_valid[0], op 01, key 15, heap_n=3, engine done 5 cycles after start -> one heap_start with instruction 01 and key 15; resp_valid=0001 and resp_err=0 eight cycles after request.
REQ-036 Pop: heap_arr_out=42, heap_n=10, requester 2 op 10 -> resp_valid=0100, resp_data=42, resp_err=0.
REQ-037 Boundaries: pop with heap_n=0, or push with heap_n=1023 -> no heap_start; resp_err=1 two cycles after request.
REQ-038 Fairness: all four requesters held high for 8 ops -> grant order 0,1,2,3,0,1,2,3.
REQ-039 Reset in WAIT: reset_n low during WAIT -> outputs 0 immediately and no resp_valid. With HEAP_ARB_TIMEOUT_EN and heap_done stuck at 0 -> resp_err=1 after 4095 WAIT cycles.
